// File: rtl/alu.sv
// 8-bit registered ALU: add/sub/rsub with carry plus five bitwise ops.
// Define ALU_FLAGS_EN to add registered zero and overflow flags.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] oper,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
`ifdef ALU_FLAGS_EN
  ,
  output logic       zero,
  output logic       ovf
`endif
);

  logic [7:0] x;
  logic [7:0] y;
  logic       ci;
  logic       arith;
  logic [8:0] add9;
  logic [7:0] res_d;
  logic       c_d;

  logic [7:0] sum_q;
  logic       c_q;

  // Subtractions reuse the adder with an inverted addend.
  always_comb begin
    x     = a;
    y     = b;
    ci    = c_in;
    arith = 1'b1;
    unique case (oper)
      3'd0: begin
        x  = a;
        y  = b;
        ci = c_in;
      end
      3'd1: begin
        x  = a;
        y  = ~b;
        ci = c_in;
      end
      3'd2: begin
        x  = b;
        y  = ~a;
        ci = ~c_in;
      end
      default: arith = 1'b0;
    endcase
  end

  assign add9 = {1'b0, x} + {1'b0, y} + {8'd0, ci};

  always_comb begin
    res_d = 8'h00;
    c_d   = 1'b0;
    unique case (oper)
      3'd0, 3'd1, 3'd2: begin
        res_d = add9[7:0];
        c_d   = add9[8];
      end
      3'd3: res_d = a | b;
      3'd4: res_d = a & b;
      3'd5: res_d = ~a & b;
      3'd6: res_d = a ^ b;
      3'd7: res_d = ~(a ^ b);
      default: res_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
      c_q   <= 1'b0;
    end else begin
      sum_q <= res_d;
      c_q   <= c_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_q;

`ifdef ALU_FLAGS_EN
  logic zero_d;
  logic ovf_d;
  logic zero_q;
  logic ovf_q;

  assign zero_d = (res_d == 8'h00);
  assign ovf_d  = arith && (x[7] == y[7]) && (res_d[7] != x[7]);

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu; each vector is checked one edge
// after it is applied, flags only when ALU_FLAGS_EN is defined.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [2:0] oper;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic [7:0] sum;
  logic       c_out;
`ifdef ALU_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  int n_cmp;
  int n_bad;

  alu dut (
    .clk  (clk),
    .rst  (rst),
    .oper (oper),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .sum  (sum),
    .c_out(c_out)
`ifdef ALU_FLAGS_EN
    ,
    .zero (zero),
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] oper;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [7:0] e_sum;
    logic       e_c;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [2:0] op,
                              logic [7:0] va, logic [7:0] vb,
                              logic ci, logic [7:0] es,
                              logic ec, logic eo);
    vec_t v;
    v.rst   = r;
    v.oper  = op;
    v.a     = va;
    v.b     = vb;
    v.c_in  = ci;
    v.e_sum = es;
    v.e_c   = ec;
    v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] es,
                       logic ec, logic eo);
    n_cmp++;
    if (sum !== es) begin
      n_bad++;
      $display("FAIL %s sum got %h want %h", name, sum, es);
    end
    n_cmp++;
    if (c_out !== ec) begin
      n_bad++;
      $display("FAIL %s c_out got %b want %b", name, c_out, ec);
    end
`ifdef ALU_FLAGS_EN
    n_cmp++;
    if (zero !== (es == 8'h00)) begin
      n_bad++;
      $display("FAIL %s zero got %b want %b", name, zero,
               (es == 8'h00));
    end
    n_cmp++;
    if (ovf !== eo) begin
      n_bad++;
      $display("FAIL %s ovf got %b want %b", name, ovf, eo);
    end
`else
    if (eo === 1'bx) $display("unused ovf expectation");
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    oper  = 3'd0;
    a     = 8'h9D;
    b     = 8'hD7;
    c_in  = 1'b0;

    // reset, then arithmetic sweep
    vecs.push_back(mk(1, 0, 8'h9D, 8'hD7, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h9D, 8'hD7, 0, 8'h74, 1, 1));
    vecs.push_back(mk(0, 0, 8'h9D, 8'hD7, 1, 8'h75, 1, 1));
    vecs.push_back(mk(0, 1, 8'h9D, 8'hD7, 0, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h9D, 8'hD7, 1, 8'hC6, 0, 0));
    vecs.push_back(mk(0, 2, 8'h9D, 8'hD7, 0, 8'h3A, 1, 0));
    vecs.push_back(mk(0, 2, 8'h9D, 8'hD7, 1, 8'h39, 1, 0));
    // logic sweep, both carry-in values
    vecs.push_back(mk(0, 3, 8'h9D, 8'hD7, 0, 8'hDF, 0, 0));
    vecs.push_back(mk(0, 3, 8'h9D, 8'hD7, 1, 8'hDF, 0, 0));
    vecs.push_back(mk(0, 4, 8'h9D, 8'hD7, 0, 8'h95, 0, 0));
    vecs.push_back(mk(0, 4, 8'h9D, 8'hD7, 1, 8'h95, 0, 0));
    vecs.push_back(mk(0, 5, 8'h9D, 8'hD7, 0, 8'h42, 0, 0));
    vecs.push_back(mk(0, 5, 8'h9D, 8'hD7, 1, 8'h42, 0, 0));
    vecs.push_back(mk(0, 6, 8'h9D, 8'hD7, 0, 8'h4A, 0, 0));
    vecs.push_back(mk(0, 6, 8'h9D, 8'hD7, 1, 8'h4A, 0, 0));
    vecs.push_back(mk(0, 7, 8'h9D, 8'hD7, 0, 8'hB5, 0, 0));
    vecs.push_back(mk(0, 7, 8'h9D, 8'hD7, 1, 8'hB5, 0, 0));
    // overflow and zero corners
    vecs.push_back(mk(0, 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1));
    vecs.push_back(mk(0, 1, 8'h55, 8'h55, 1, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h01, 1, 8'hFF, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0));
    // back-to-back opcodes, reset mid-stream, resume
    vecs.push_back(mk(0, 0, 8'h9D, 8'hD7, 0, 8'h74, 1, 1));
    vecs.push_back(mk(0, 1, 8'h9D, 8'hD7, 0, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 2, 8'h9D, 8'hD7, 0, 8'h3A, 1, 0));
    vecs.push_back(mk(1, 3, 8'h9D, 8'hD7, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4, 8'h9D, 8'hD7, 0, 8'h95, 0, 0));
    vecs.push_back(mk(0, 5, 8'h9D, 8'hD7, 0, 8'h42, 0, 0));
    vecs.push_back(mk(0, 6, 8'h9D, 8'hD7, 0, 8'h4A, 0, 0));
    vecs.push_back(mk(0, 7, 8'h9D, 8'hD7, 0, 8'hB5, 0, 0));
    vecs.push_back(mk(0, 0, 8'h9D, 8'hD7, 1, 8'h75, 1, 1));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      oper = vecs[i].oper;
      a    = vecs[i].a;
      b    = vecs[i].b;
      c_in = vecs[i].c_in;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_sum,
            vecs[i].e_c, vecs[i].e_ovf);
    end

    // inputs changed between edges must not reach the outputs
    oper = 3'd3;
    a    = 8'h00;
    b    = 8'h00;
    c_in = 1'b0;
    #3;
    check("hold", 8'h75, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("after_hold", 8'h00, 1'b0, 1'b0);

    // reset held for two edges keeps reset values
    rst = 1'b1;
    oper = 3'd0;
    a = 8'hFF;
    b = 8'h01;
    @(posedge clk);
    #1;
    check("rst_hold1", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold2", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
